// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes, ALU functions, condition codes.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // ALU functions
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // An instruction further down the pipe that faulted or halted must not
  // see its younger OPQ siblings alter architectural flags.
  function automatic logic is_exception(input logic [2:0] stat);
    return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bus bundle: E_* pipeline register in, forwarding taps and M_* register out.
// Latency: n/a (wires only); e_* are combinational, M_* are registered inside the stage.
// Backpressure: none; the stage advances every cycle, M_bubble squashes the captured slot.
// Modports: master = upstream/controller side (drives E_*, m_stat, W_stat, M_bubble);
//           slave  = execute_stage (drives e_valE, e_dstE, e_cnd and the M_* register).
interface execute_stage_if #(
  parameter int WORD = 64
);
  logic [2:0]      E_stat;
  logic [3:0]      E_icode;
  logic [3:0]      E_ifun;
  logic [WORD-1:0] E_valC;
  logic [WORD-1:0] E_valA;
  logic [WORD-1:0] E_valB;
  logic [3:0]      E_dstE;
  logic [3:0]      E_dstM;
  logic [2:0]      m_stat;
  logic [2:0]      W_stat;
  logic            M_bubble;

  logic [WORD-1:0] e_valE;
  logic [3:0]      e_dstE;
  logic            e_cnd;

  logic [2:0]      M_stat;
  logic [3:0]      M_icode;
  logic            M_cnd;
  logic [WORD-1:0] M_valE;
  logic [WORD-1:0] M_valA;
  logic [3:0]      M_dstE;
  logic [3:0]      M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_valE, e_dstE, e_cnd,
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_valE, e_dstE, e_cnd,
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/y86_alu.sv
// Y86-64 ALU: val_e = alu_b <op> alu_a with zero/sign/overflow flags.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_a, alu_b (WORD operands), alu_fun (4-bit function) -> val_e, zf, sf, of.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0] alu_a,
  input  logic [WORD-1:0] alu_b,
  input  logic [3:0]      alu_fun,
  output logic [WORD-1:0] val_e,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  logic [WORD-1:0] res;
  logic            ovf;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        res = alu_b + alu_a;
        ovf = (alu_a[WORD-1] == alu_b[WORD-1]) && (res[WORD-1] != alu_a[WORD-1]);
      end
      ALU_SUB: begin
        res = alu_b - alu_a;
        ovf = (alu_a[WORD-1] != alu_b[WORD-1]) && (res[WORD-1] != alu_b[WORD-1]);
      end
      ALU_AND: res = alu_b & alu_a;
      ALU_XOR: res = alu_b ^ alu_a;
      default: res = '0;
    endcase
  end

  assign val_e = res;
  assign zf    = (res == '0);
  assign sf    = res[WORD-1];
  assign of    = ovf;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, cmov/jump condition, E->M register.
// Latency: e_valE/e_dstE/e_cnd combinational; M_* and CC one cycle (rising clk).
// Backpressure: none; advances every cycle, M_bubble loads a NOP slot into M_*.
// Ports: clk, rst_n (async active-low), ex (execute_stage_if.slave: E_* in, e_* and M_* out).
module execute_stage
  import y86_pkg::*;
#(
  parameter int WORD = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  execute_stage_if.slave    ex
);

  localparam logic [WORD-1:0] EIGHT = WORD'(8);

  logic [WORD-1:0] alu_a;
  logic [WORD-1:0] alu_b;
  logic [3:0]      alu_fun;
  logic [WORD-1:0] val_e;
  cc_t             new_cc;
  cc_t             cc;
  logic            set_cc;
  logic            cnd;
  logic [3:0]      dst_e;

  always_comb begin
    alu_a = '0;
    case (ex.E_icode)
      I_CMOVXX, I_OPQ:                alu_a = ex.E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = ex.E_valC;
      I_CALL, I_PUSHQ:                alu_a = '0 - EIGHT;
      I_RET, I_POPQ:                  alu_a = EIGHT;
      default:                        alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (ex.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_PUSHQ, I_RET, I_POPQ:         alu_b = ex.E_valB;
      default:                        alu_b = '0;
    endcase
  end

  assign alu_fun = (ex.E_icode == I_OPQ) ? ex.E_ifun : ALU_ADD;

  y86_alu #(.WORD(WORD)) u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .val_e   (val_e),
    .zf      (new_cc.zf),
    .sf      (new_cc.sf),
    .of      (new_cc.of)
  );

  assign set_cc = (ex.E_icode == I_OPQ) && !is_exception(ex.m_stat) && !is_exception(ex.W_stat);

  // CC update is independent of M_bubble: bubbling M does not undo the OPQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (set_cc) begin
      cc <= new_cc;
    end
  end

  // Condition uses the registered flags, i.e. those left by the previous OPQ.
  always_comb begin
    cnd = 1'b0;
    case (ex.E_ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (cc.sf ^ cc.of) | cc.zf;
      4'd2:    cnd = cc.sf ^ cc.of;
      4'd3:    cnd = cc.zf;
      4'd4:    cnd = !cc.zf;
      4'd5:    cnd = !(cc.sf ^ cc.of);
      4'd6:    cnd = !(cc.sf ^ cc.of) && !cc.zf;
      default: cnd = 1'b0;
    endcase
  end

  assign dst_e = ((ex.E_icode == I_CMOVXX) && !cnd) ? RNONE : ex.E_dstE;

  assign ex.e_valE = val_e;
  assign ex.e_dstE = dst_e;
  assign ex.e_cnd  = cnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.M_stat  <= S_AOK;
      ex.M_icode <= I_NOP;
      ex.M_cnd   <= 1'b0;
      ex.M_valE  <= '0;
      ex.M_valA  <= '0;
      ex.M_dstE  <= RNONE;
      ex.M_dstM  <= RNONE;
    end else if (ex.M_bubble) begin
      ex.M_stat  <= S_AOK;
      ex.M_icode <= I_NOP;
      ex.M_cnd   <= 1'b0;
      ex.M_valE  <= '0;
      ex.M_valA  <= '0;
      ex.M_dstE  <= RNONE;
      ex.M_dstM  <= RNONE;
    end else begin
      ex.M_stat  <= ex.E_stat;
      ex.M_icode <= ex.E_icode;
      ex.M_cnd   <= cnd;
      ex.M_valE  <= val_e;
      ex.M_valA  <= ex.E_valA;
      ex.M_dstE  <= dst_e;
      ex.M_dstM  <= ex.E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed vectors, scoreboard queue, negedge monitor.
// Each vector carries hand-computed combinational results; the M_* expectation
// for a cycle is the previous vector's captured slot (or bubble on reset/M_bubble).
module tb_execute_stage;

  localparam int WORD = 64;

  typedef struct {
    bit          rst;
    bit          bub;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [2:0]  mstat;
    logic [2:0]  wstat;
    logic [63:0] x_vale;
    logic [3:0]  x_dste;
    logic        x_cnd;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] vale;
    logic [3:0]  dste;
    logic        cnd;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vale;
    logic [63:0] m_vala;
    logic [3:0]  m_dste;
    logic [3:0]  m_dstm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  execute_stage_if #(.WORD(WORD)) ex_if ();

  execute_stage #(.WORD(WORD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if.slave)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mkv(bit rst, bit bub, logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                               logic [63:0] valc, logic [63:0] vala, logic [63:0] valb,
                               logic [3:0] dste, logic [3:0] dstm, logic [2:0] mstat, logic [2:0] wstat,
                               logic [63:0] x_vale, logic [3:0] x_dste, logic x_cnd);
    vec_t v;
    v.rst = rst; v.bub = bub; v.stat = stat; v.icode = icode; v.ifun = ifun;
    v.valc = valc; v.vala = vala; v.valb = valb; v.dste = dste; v.dstm = dstm;
    v.mstat = mstat; v.wstat = wstat; v.x_vale = x_vale; v.x_dste = x_dste; v.x_cnd = x_cnd;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d.%s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("e_valE",  e.id, ex_if.e_valE,        e.vale);
      chk("e_dstE",  e.id, 64'(ex_if.e_dstE),   64'(e.dste));
      chk("e_cnd",   e.id, 64'(ex_if.e_cnd),    64'(e.cnd));
      chk("M_stat",  e.id, 64'(ex_if.M_stat),   64'(e.m_stat));
      chk("M_icode", e.id, 64'(ex_if.M_icode),  64'(e.m_icode));
      chk("M_cnd",   e.id, 64'(ex_if.M_cnd),    64'(e.m_cnd));
      chk("M_valE",  e.id, ex_if.M_valE,        e.m_vale);
      chk("M_valA",  e.id, ex_if.M_valA,        e.m_vala);
      chk("M_dstE",  e.id, 64'(ex_if.M_dstE),   64'(e.m_dste));
      chk("M_dstM",  e.id, 64'(ex_if.M_dstM),   64'(e.m_dstm));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t m_model;
    exp_t bubble;
    exp_t e;
    vec_t v;

    rst_n = 1'b0;
    ex_if.E_stat = 3'd1; ex_if.E_icode = 4'h1; ex_if.E_ifun = 4'h0;
    ex_if.E_valC = '0; ex_if.E_valA = '0; ex_if.E_valB = '0;
    ex_if.E_dstE = 4'hF; ex_if.E_dstM = 4'hF;
    ex_if.m_stat = 3'd1; ex_if.W_stat = 3'd1; ex_if.M_bubble = 1'b0;

    //                 rst bub st  ic    fn    valC   valA                    valB                    dE    dM    m     W     x_valE                  x_dE  x_cnd
    vecs.push_back(mkv(1, 0, 3'd1, 4'h1, 4'h0, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 0 reset, NOP
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h40,64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 1 je: ZF=1 from reset
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h0, 64'h0, 64'h1,                  64'h2,                  4'h2, 4'hF, 3'd1, 3'd1, 64'h3,                  4'h2, 1)); // 2 addq 1+2
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 3 je: ZF=0
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h1, 64'h0, 64'h5,                  64'h5,                  4'h2, 4'hF, 3'd1, 3'd1, 64'h0,                  4'h2, 0)); // 4 subq 5-5, le on old CC
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 5 je: ZF=1
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h0, 64'h0, 64'h7FFFFFFFFFFFFFFF,  64'h7FFFFFFFFFFFFFFF,  4'h1, 4'hF, 3'd1, 3'd1, 64'hFFFFFFFFFFFFFFFE,  4'h1, 1)); // 6 add overflow
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h2, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 7 jl: SF=1,OF=1
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h4, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 8 jne: ZF=0
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h2, 64'h0, 64'hF0,                 64'h0F,                 4'h5, 4'hF, 3'd1, 3'd1, 64'h0,                  4'h5, 0)); // 9 andq -> 0
    vecs.push_back(mkv(0, 0, 3'd1, 4'h2, 4'h2, 64'h0, 64'h1234,               64'h0,                  4'h3, 4'hF, 3'd1, 3'd1, 64'h1234,               4'hF, 0)); // 10 cmovl not taken
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h1, 64'h0, 64'h1,                  64'h0,                  4'h4, 4'hF, 3'd1, 3'd1, 64'hFFFFFFFFFFFFFFFF,  4'h4, 1)); // 11 subq 0-1
    vecs.push_back(mkv(0, 0, 3'd1, 4'h2, 4'h2, 64'h0, 64'h55,                 64'h0,                  4'h3, 4'hF, 3'd1, 3'd1, 64'h55,                 4'h3, 1)); // 12 cmovl taken
    vecs.push_back(mkv(0, 0, 3'd1, 4'hA, 4'h0, 64'h0, 64'h9,                  64'h100,                4'h4, 4'hF, 3'd1, 3'd1, 64'hF8,                 4'h4, 1)); // 13 pushq
    vecs.push_back(mkv(0, 0, 3'd1, 4'hB, 4'h0, 64'h0, 64'h100,                64'h100,                4'h4, 4'h7, 3'd1, 3'd1, 64'h108,                4'h4, 1)); // 14 popq
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h2, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 15 jl: CC untouched by push/pop
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h3, 64'h0, 64'hFF,                 64'hFF,                 4'h2, 4'hF, 3'd3, 3'd1, 64'h0,                  4'h2, 0)); // 16 xorq, m_stat=ADR
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 17 je: CC held
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h3, 64'h0, 64'hFF,                 64'hFF,                 4'h2, 4'hF, 3'd1, 3'd4, 64'h0,                  4'h2, 0)); // 18 xorq, W_stat=INS
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 19 je: CC held
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h3, 64'h0, 64'hFF,                 64'hFF,                 4'h2, 4'hF, 3'd1, 3'd1, 64'h0,                  4'h2, 0)); // 20 xorq, all AOK
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 21 je: CC updated
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h1, 64'h0, 64'h1,                  64'h8000000000000000,  4'h6, 4'hF, 3'd1, 3'd1, 64'h7FFFFFFFFFFFFFFF,  4'h6, 1)); // 22 sub overflow
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h5, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 23 jge: OF=1,SF=0
    vecs.push_back(mkv(0, 0, 3'd1, 4'h6, 4'h4, 64'h0, 64'h3,                  64'h4,                  4'h2, 4'hF, 3'd1, 3'd1, 64'h0,                  4'h2, 1)); // 24 opq ifun 4 -> 0
    vecs.push_back(mkv(0, 1, 3'd1, 4'h6, 4'h0, 64'h0, 64'h1,                  64'h1,                  4'h2, 4'hF, 3'd1, 3'd1, 64'h2,                  4'h2, 1)); // 25 addq with M_bubble
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 26 je: CC set despite bubble
    vecs.push_back(mkv(1, 0, 3'd1, 4'h7, 4'h4, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 0)); // 27 mid-stream reset, jne
    vecs.push_back(mkv(0, 0, 3'd1, 4'h7, 4'h3, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 28 je after reset
    vecs.push_back(mkv(0, 0, 3'd2, 4'h0, 4'h0, 64'h0, 64'h77,                 64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 29 halt
    vecs.push_back(mkv(0, 0, 3'd1, 4'h1, 4'h0, 64'h0, 64'h0,                  64'h0,                  4'hF, 4'hF, 3'd1, 3'd1, 64'h0,                  4'hF, 1)); // 30 nop

    bubble.id = 0; bubble.vale = '0; bubble.dste = 4'hF; bubble.cnd = 1'b0;
    bubble.m_stat = 3'd1; bubble.m_icode = 4'h1; bubble.m_cnd = 1'b0;
    bubble.m_vale = '0; bubble.m_vala = '0; bubble.m_dste = 4'hF; bubble.m_dstm = 4'hF;
    m_model = bubble;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      rst_n = v.rst ? 1'b0 : 1'b1;
      ex_if.E_stat = v.stat; ex_if.E_icode = v.icode; ex_if.E_ifun = v.ifun;
      ex_if.E_valC = v.valc; ex_if.E_valA = v.vala; ex_if.E_valB = v.valb;
      ex_if.E_dstE = v.dste; ex_if.E_dstM = v.dstm;
      ex_if.m_stat = v.mstat; ex_if.W_stat = v.wstat; ex_if.M_bubble = v.bub;

      e = v.rst ? bubble : m_model;
      e.id = i; e.vale = v.x_vale; e.dste = v.x_dste; e.cnd = v.x_cnd;
      sb.push_back(e);

      if (v.rst || v.bub) begin
        m_model = bubble;
      end else begin
        m_model.m_stat = v.stat; m_model.m_icode = v.icode; m_model.m_cnd = v.x_cnd;
        m_model.m_vale = v.x_vale; m_model.m_vala = v.vala;
        m_model.m_dste = v.x_dste; m_model.m_dstm = v.dstm;
      end
    end

    @(negedge clk);
    #1;
    chk("drain", -1, 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
